alu_wb: RTL and testbench

ALU_WB -- requirements
Module: alu_wb

---
 rtl/alu_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/alu_wb.sv | 77 +++++++
 tb/tb_alu_wb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, flag indices and the result record
package alu_pkg;

   localparam int ALU_DW = 16;
   localparam int FUNC_W = 4;
   localparam int FLAG_W = 3;

   localparam int ZERO   = 0;
   localparam int PARITY = 1;
   localparam int CARRY  = 2;

   localparam logic [FUNC_W-1:0] OP_ADD  = 4'h0;
   localparam logic [FUNC_W-1:0] OP_SUB  = 4'h1;
   localparam logic [FUNC_W-1:0] OP_INC  = 4'h2;
   localparam logic [FUNC_W-1:0] OP_DEC  = 4'h3;
   localparam logic [FUNC_W-1:0] OP_AND  = 4'h4;
   localparam logic [FUNC_W-1:0] OP_OR   = 4'h5;
   localparam logic [FUNC_W-1:0] OP_XOR  = 4'h6;
   localparam logic [FUNC_W-1:0] OP_NOT  = 4'h7;
   localparam logic [FUNC_W-1:0] OP_SHL  = 4'h8;
   localparam logic [FUNC_W-1:0] OP_SHR  = 4'h9;
   localparam logic [FUNC_W-1:0] OP_ROL  = 4'hA;
   localparam logic [FUNC_W-1:0] OP_ROR  = 4'hB;
   localparam logic [FUNC_W-1:0] OP_PASA = 4'hC;
   localparam logic [FUNC_W-1:0] OP_PASB = 4'hD;
   localparam logic [FUNC_W-1:0] OP_NAND = 4'hE;
   localparam logic [FUNC_W-1:0] OP_NOR  = 4'hF;

   typedef struct packed {
      logic [FUNC_W-1:0] func;
      logic [FLAG_W-1:0] flags;
      logic [ALU_DW-1:0] data;
   } alu_result_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; storage is unreset, pointers and count reset
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata;
   end

   assign rdata = mem_q[rptr_q];
   assign count = count_q;

endmodule

// File: rtl/alu_wb.sv
// rtl/alu_wb.sv - ALU result write-back queue with sticky flags and drop counter
module alu_wb
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 16,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_data,
   input  logic [FLAG_W-1:0] in_flags,
   input  logic [FUNC_W-1:0] in_func,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [FLAG_W-1:0] out_flags,
   output logic [FUNC_W-1:0] out_func,
   output logic [CW-1:0]     count,
   output logic [FLAG_W-1:0] sticky_flags,
   input  logic              flag_clr,
   output logic [7:0]        drop_cnt
);

   localparam int RW = FUNC_W + FLAG_W + DW;

   logic              push, pop;
   logic              init_q, init_d;
   logic [FLAG_W-1:0] sticky_q, sticky_d;
   logic [7:0]        drop_q, drop_d;
   logic [RW-1:0]     rdata;

   // init_q keeps in_ready low while reset is held and sets on the first edge after
   assign in_ready  = init_q && (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   sync_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata ({in_func, in_flags, in_data}),
      .rdata (rdata),
      .count (count)
   );

   assign {out_func, out_flags, out_data} = rdata;

   always_comb begin
      init_d   = 1'b1;
      sticky_d = sticky_q;
      drop_d   = drop_q;
      if (flag_clr)  sticky_d = push ? in_flags : '0;
      else if (push) sticky_d = sticky_q | in_flags;
      if (in_valid && !in_ready && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q   <= 1'b0;
         sticky_q <= '0;
         drop_q   <= '0;
      end else begin
         init_q   <= init_d;
         sticky_q <= sticky_d;
         drop_q   <= drop_d;
      end
   end

   assign sticky_flags = sticky_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_alu_wb.sv
// tb/tb_alu_wb.sv - scoreboard bench for alu_wb
module tb_alu_wb;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int DW    = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [15:0] in_data;
   logic [2:0]  in_flags;
   logic [3:0]  in_func;
   logic        out_valid, out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_flags;
   logic [3:0]  out_func;
   logic [2:0]  count;
   logic [2:0]  sticky_flags;
   logic        flag_clr;
   logic [7:0]  drop_cnt;

   alu_wb #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_flags     (in_flags),
      .in_func      (in_func),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_flags    (out_flags),
      .out_func     (out_func),
      .count        (count),
      .sticky_flags (sticky_flags),
      .flag_clr     (flag_clr),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   alu_result_t sb[$];
   logic [2:0]  m_sticky;
   logic [7:0]  m_drop;
   logic        m_init;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] f, input logic [2:0] fl, input logic [15:0] d);
      in_valid = v;
      in_func  = f;
      in_flags = fl;
      in_data  = d;
   endtask

   // called at a falling edge: compare, advance the model, move to the next falling edge
   task automatic step();
      logic        exp_valid, exp_ready, acc, pd;
      alu_result_t r;
      #1;
      exp_valid = (sb.size() != 0);
      exp_ready = m_init && (sb.size() != DEPTH);
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, exp_ready);
      check("count", count, sb.size());
      check("sticky", sticky_flags, m_sticky);
      check("drop_cnt", drop_cnt, m_drop);
      if (exp_valid) begin
         check("out_data", out_data, sb[0].data);
         check("out_flags", out_flags, sb[0].flags);
         check("out_func", out_func, sb[0].func);
      end
      acc = in_valid && exp_ready;
      pd  = exp_valid && out_ready;
      if (pd) void'(sb.pop_front());
      if (acc) begin
         r.func  = in_func;
         r.flags = in_flags;
         r.data  = in_data;
         sb.push_back(r);
      end
      if (flag_clr) m_sticky = acc ? in_flags : 3'b000;
      else if (acc) m_sticky = m_sticky | in_flags;
      if (in_valid && !exp_ready && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      m_init = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      out_ready = 1'b1;
      while (sb.size() != 0 && guard < 20) begin
         step();
         guard++;
      end
      check("drain_bound", guard < 20, 1'b1);
      out_ready = 1'b0;
      step();
   endtask

   task automatic model_reset();
      sb.delete();
      m_sticky = 3'b000;
      m_drop   = 8'd0;
      m_init   = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      flag_clr  = 1'b0;
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_count", count, 3'd0);
      check("rst_sticky", sticky_flags, 3'b000);
      check("rst_drop", drop_cnt, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // single push: visible one cycle later
      drive(1'b1, OP_OR, 3'b000, 16'h0001);
      step();
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      #1;
      check("s1_out_valid", out_valid, 1'b1);
      check("s1_out_data", out_data, 16'h0001);
      check("s1_out_func", out_func, 4'd5);
      check("s1_count", count, 3'd1);
      step();
      drain();

      // fill, then offer three while full
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 4'(i + 8), 3'(i), 16'hA000 + 16'(i));
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'hF, 3'b111, 16'hDEAD);
         step();
      end
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      #1;
      check("full_in_ready", in_ready, 1'b0);
      check("full_count", count, 3'd4);
      check("full_drop", drop_cnt, 8'd3);
      check("full_head", out_data, 16'hA000);

      // full with push and pop together: only the pop happens
      drive(1'b1, 4'h1, 3'b001, 16'hBEEF);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      #1;
      check("fullpp_count", count, 3'd3);
      check("fullpp_head", out_data, 16'hA001);
      step();
      drain();

      // sticky flags and clear-with-push
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      drive(1'b1, OP_ADD, 3'b001, 16'h0011);
      step();
      drive(1'b1, OP_SUB, 3'b100, 16'h0022);
      step();
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      #1;
      check("sticky_or", sticky_flags, 3'b101);
      drive(1'b1, OP_XOR, 3'b010, 16'h0033);
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      #1;
      check("sticky_clr_push", sticky_flags, 3'b010);
      step();
      drain();

      // random traffic to exercise pointer wrap
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom), 16'($urandom));
         out_ready = 1'($urandom_range(0, 1));
         flag_clr  = ($urandom_range(0, 15) == 0);
         step();
      end
      flag_clr = 1'b0;
      drain();

      // saturation of the drop counter
      for (int i = 0; i < DEPTH + 300; i++) begin
         drive(1'b1, 4'(i), 3'(i), 16'(i * 3));
         step();
      end
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      #1;
      check("drop_sat", drop_cnt, 8'd255);
      step();
      drain();

      // asynchronous reset with two entries queued
      drive(1'b1, OP_AND, 3'b011, 16'h1111);
      step();
      drive(1'b1, OP_NOT, 3'b100, 16'h2222);
      step();
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      #1;
      check("pre_rst_count", count, 3'd2);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_count", count, 3'd0);
      check("arst_in_ready", in_ready, 1'b0);
      check("arst_drop", drop_cnt, 8'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      drive(1'b1, OP_ROL, 3'b001, 16'h3333);
      step();
      drive(1'b1, OP_ROR, 3'b010, 16'h4444);
      step();
      drive(1'b0, 4'h0, 3'b000, 16'h0);
      #1;
      check("post_rst_head", out_data, 16'h3333);
      step();
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
